// File: rtl/sprite_render_pkg.sv
// Shared types and sizing helpers for the sprite scanline renderer.
package sprite_render_pkg;

  localparam int SPRITE_W_DEF = 8;
  localparam int SPRITE_H_DEF = 8;
  localparam int POS_W_DEF    = 16;

  typedef enum logic [2:0] {
    IDLE, WAIT_V, FETCH, LOAD, WAIT_H, DRAW, WAIT_NEXT
  } state_t;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_row_shifter.sv
// One bitmap row: parallel load from ROM, MSB-first serial shift, pixel counter.
// SPRITE_RENDERER_MIRROR_EN adds a bit-reversed load path.
module sprite_row_shifter
  import sprite_render_pkg::*;
#(
  parameter int SPRITE_W = SPRITE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                shift,
  input  logic                clr_cnt,
`ifdef SPRITE_RENDERER_MIRROR_EN
  input  logic                mirror,
`endif
  input  logic [SPRITE_W-1:0] rom_data,
  output logic                pix,
  output logic                last
);

  localparam int CW = addr_w(SPRITE_W);

  logic [SPRITE_W-1:0] shreg;
  logic [CW-1:0]       bit_cnt;
  logic [SPRITE_W-1:0] row_in;

`ifdef SPRITE_RENDERER_MIRROR_EN
  logic [SPRITE_W-1:0] row_rev;
  always_comb begin
    row_rev = '0;
    for (int i = 0; i < SPRITE_W; i++) row_rev[i] = rom_data[SPRITE_W-1-i];
  end
  assign row_in = mirror ? row_rev : rom_data;
`else
  assign row_in = rom_data;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      if (load)       shreg <= row_in;
      else if (shift) shreg <= shreg << 1;
      if (clr_cnt)    bit_cnt <= '0;
      else if (shift) bit_cnt <= bit_cnt + CW'(1);
    end
  end

  assign pix  = shreg[SPRITE_W-1];
  assign last = (bit_cnt == CW'(SPRITE_W-1));

endmodule

// File: rtl/sprite_scanline_renderer.sv
// Per-scanline sprite fetch/serialise FSM driven by the sync generator counters.
// Optional horizontal mirroring: define SPRITE_RENDERER_MIRROR_EN to add hmirror.
module sprite_scanline_renderer
  import sprite_render_pkg::*;
#(
  parameter  int SPRITE_W = SPRITE_W_DEF,
  parameter  int SPRITE_H = SPRITE_H_DEF,
  parameter  int POS_W    = POS_W_DEF,
  localparam int AW       = addr_w(SPRITE_H)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [POS_W-1:0]    hpos,
  input  logic [POS_W-1:0]    vpos,
  input  logic                display_on,
  input  logic [POS_W-1:0]    sprite_x,
  input  logic [POS_W-1:0]    sprite_y,
`ifdef SPRITE_RENDERER_MIRROR_EN
  input  logic                hmirror,
`endif
  output logic [AW-1:0]       rom_addr,
  input  logic [SPRITE_W-1:0] rom_data,
  output logic                gfx,
  output logic                busy
);

  state_t           state, state_n;
  logic [POS_W-1:0] x_lat, y_lat;
  logic [AW-1:0]    line_cnt;
  logic             frame_start, line_start, last_row;
  logic             start_draw, row_done;
  logic             pix, last;

  assign line_start  = (hpos == '0);
  assign frame_start = line_start && (vpos == '0);
  assign last_row    = (line_cnt == AW'(SPRITE_H-1));
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    start_draw = 1'b0;
    row_done   = 1'b0;
    case (state)
      IDLE:      ;
      WAIT_V:    if (line_start && vpos == y_lat) state_n = FETCH;
      FETCH:     state_n = LOAD;
      LOAD:      state_n = WAIT_H;
      WAIT_H:
        if (hpos == x_lat) begin
          state_n    = DRAW;
          start_draw = 1'b1;
        end else if (line_start) begin
          row_done = 1'b1;  // start column never reached on this line
        end
      DRAW:      if (last) row_done = 1'b1;
      WAIT_NEXT: if (line_start) state_n = FETCH;
      default:   state_n = IDLE;
    endcase
    if (row_done) state_n = last_row ? IDLE : WAIT_NEXT;
    // Frame start restarts from any state and overrides everything above.
    if (frame_start) begin
      state_n    = WAIT_V;
      start_draw = 1'b0;
      row_done   = 1'b0;
    end
  end

`ifdef SPRITE_RENDERER_MIRROR_EN
  logic mirror_lat;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            mirror_lat <= 1'b0;
    else if (frame_start) mirror_lat <= hmirror;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_lat    <= '0;
      y_lat    <= '0;
      line_cnt <= '0;
      rom_addr <= '0;
      gfx      <= 1'b0;
    end else begin
      gfx <= (state == DRAW) && pix && display_on;
      if (frame_start) begin
        x_lat    <= sprite_x;
        y_lat    <= sprite_y;
        line_cnt <= '0;
      end else if (row_done && !last_row) begin
        line_cnt <= line_cnt + AW'(1);
      end
      // Address is presented during FETCH so the ROM row is ready in LOAD.
      if (state_n == FETCH) rom_addr <= line_cnt;
    end
  end

  sprite_row_shifter #(.SPRITE_W(SPRITE_W)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (state == LOAD),
    .shift    (state == DRAW),
    .clr_cnt  (start_draw),
`ifdef SPRITE_RENDERER_MIRROR_EN
    .mirror   (mirror_lat),
`endif
    .rom_data (rom_data),
    .pix      (pix),
    .last     (last)
  );

endmodule

// File: tb/tb_sprite_scanline_renderer.sv
// Self-checking bench: a sync-generator stimulus loop feeds the renderer and a
// scoreboard queue of expected lit pixels (v*4096+h) is popped as gfx lights.
module tb_sprite_scanline_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] hpos, vpos, sprite_x, sprite_y;
  logic        display_on;
  logic [2:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        gfx, busy;
`ifdef SPRITE_RENDERER_MIRROR_EN
  logic        hmirror;
`endif

  sprite_scanline_renderer dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
`ifdef SPRITE_RENDERER_MIRROR_EN
    .hmirror    (hmirror),
`endif
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .gfx        (gfx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [8];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int h_total, h_vis, v_total;
  int exp_q[$];
  int compared = 0, mismatched = 0;
  int edge_v, edge_h;
  bit mon_en = 1'b0;

  // gfx after an edge belongs to the pixel position sampled at that edge.
  always @(posedge clk) begin
    edge_v = int'(vpos);
    edge_h = int'(hpos);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (gfx === 1'b1) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL gfx_extra: lit at v=%0d h=%0d, required dark", edge_v, edge_h);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (e != edge_v * 4096 + edge_h) begin
            mismatched++;
            $display("FAIL gfx_pos: lit at v=%0d h=%0d, required next at v=%0d h=%0d",
                     edge_v, edge_h, e / 4096, e % 4096);
          end
        end
      end else if (gfx !== 1'b0) begin
        compared++;
        mismatched++;
        $display("FAIL gfx_x: gfx=%b at v=%0d h=%0d, required 0/1", gfx, edge_v, edge_h);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation time limit reached, required $finish");
    $fatal(1, "timeout");
  end

  // One full frame from frame start; optional mid-frame sprite_y change and
  // optional async reset injected right after the edge tagged rst_tag.
  task automatic run_frame(input int x, input int y, input int mir,
                           input int ychg_v, input int ychg_y, input int rst_tag);
    int  fall;
    bit  rows_ok;
    logic [7:0] row;
    sprite_x = 16'(x);
    sprite_y = 16'(y);
`ifdef SPRITE_RENDERER_MIRROR_EN
    hmirror = mir[0];
`endif
    for (int r = 0; r < 8; r++) begin
      row = rom[r];
      for (int n = 0; n < 8; n++)
        if ((mir != 0 ? row[n] : row[7-n]) && (x + 1 + n) < h_vis && (y + r) < v_total)
          exp_q.push_back((y + r) * 4096 + x + 1 + n);
    end
    fall    = (y + 7) * 4096 + x + 8;
    rows_ok = 1'b1;
    for (int v = 0; v < v_total; v++) begin
      for (int h = 0; h < h_total; h++) begin
        @(negedge clk);
        if (edge_v * 4096 + edge_h == rst_tag) begin
          compared++;
          if (gfx !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset_gfx: gfx=%b, required 1 mid-draw", gfx);
          end
          #2 reset = 1'b1;
          #1;
          compared += 3;
          if (gfx !== 1'b0) begin mismatched++; $display("FAIL async_reset_gfx: %b, required 0", gfx); end
          if (busy !== 1'b0) begin mismatched++; $display("FAIL async_reset_busy: %b, required 0", busy); end
          if (rom_addr !== 3'd0) begin mismatched++; $display("FAIL async_reset_addr: %0d, required 0", rom_addr); end
          exp_q.delete();
          rows_ok = 1'b0;
          fall    = -1;
        end else if (reset) begin
          reset = 1'b0;
        end
        if (rows_ok && edge_h == 0 && edge_v >= y && edge_v < y + 8) begin
          compared++;
          if (rom_addr !== 3'(edge_v - y)) begin
            mismatched++;
            $display("FAIL rom_addr: %0d on line %0d, required %0d", rom_addr, edge_v, edge_v - y);
          end
        end
        if (fall >= 0 && (edge_v * 4096 + edge_h == fall || edge_v * 4096 + edge_h == fall - 1)) begin
          compared++;
          if (busy !== (edge_v * 4096 + edge_h == fall - 1)) begin
            mismatched++;
            $display("FAIL busy_fall: busy=%b at v=%0d h=%0d, required %b",
                     busy, edge_v, edge_h, edge_v * 4096 + edge_h == fall - 1);
          end
        end
        if (v == ychg_v && h == 5) sprite_y = 16'(ychg_y);
        hpos       = 16'(h);
        vpos       = 16'(v);
        display_on = (h < h_vis) && (v < v_total);
      end
    end
    @(negedge clk);
    compared += 2;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL missing_pixels: %0d left, next v=%0d h=%0d, required 0 left",
               exp_q.size(), exp_q[0] / 4096, exp_q[0] % 4096);
      exp_q.delete();
    end
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_end: %b at frame end, required 0", busy);
    end
  endtask

  task automatic set_rom(input logic [7:0] base, input bit diag);
    for (int r = 0; r < 8; r++) rom[r] = diag ? (8'h01 << r) : base;
  endtask

  task automatic test_reset;
    #2;
    compared += 3;
    if (gfx !== 1'b0) begin mismatched++; $display("FAIL reset_gfx: %b, required 0", gfx); end
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: %b, required 0", busy); end
    if (rom_addr !== 3'd0) begin mismatched++; $display("FAIL reset_addr: %0d, required 0", rom_addr); end
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_reset_mid_draw;
    h_total = 64; h_vis = 48; v_total = 20;
    set_rom(8'hFF, 1'b0);
    run_frame(20, 10, 0, -1, 0, 10 * 4096 + 24);
  endtask

  task automatic test_single_row;
    h_total = 64; h_vis = 48; v_total = 20;
    set_rom(8'h00, 1'b0);
    rom[0] = 8'b1000_0001;
    run_frame(20, 10, 0, -1, 0, -1);
  endtask

  task automatic test_diagonal;
    h_total = 64; h_vis = 48; v_total = 20;
    set_rom(8'h00, 1'b1);
    run_frame(20, 10, 0, -1, 0, -1);
  endtask

  task automatic test_clip_right;
    h_total = 650; h_vis = 640; v_total = 20;
    set_rom(8'hFF, 1'b0);
    run_frame(636, 10, 0, -1, 0, -1);
  endtask

  task automatic test_y_change;
    h_total = 64; h_vis = 48; v_total = 60;
    set_rom(8'hA5, 1'b0);
    run_frame(20, 10, 0, 12, 50, -1);
    run_frame(20, 50, 0, -1, 0, -1);
  endtask

`ifdef SPRITE_RENDERER_MIRROR_EN
  task automatic test_mirror;
    h_total = 64; h_vis = 48; v_total = 20;
    set_rom(8'h00, 1'b0);
    rom[0] = 8'b1100_0000;
    run_frame(20, 10, 1, -1, 0, -1);
    hmirror = 1'b0;
  endtask
`endif

  initial begin
    reset      = 1'b1;
    hpos       = 16'd5;
    vpos       = 16'd5;
    display_on = 1'b0;
    sprite_x   = '0;
    sprite_y   = '0;
`ifdef SPRITE_RENDERER_MIRROR_EN
    hmirror    = 1'b0;
`endif
    set_rom(8'h00, 1'b0);
    test_reset;
    test_reset_mid_draw;
    test_single_row;
    test_diagonal;
    test_clip_right;
    test_y_change;
`ifdef SPRITE_RENDERER_MIRROR_EN
    test_mirror;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
